// File: rtl/fp_pkg.sv
// Shared types and constants for the round-robin FP compare scheduler.
// Holds state encoding, IEEE-754 field positions and the compare rule.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int SIGN_BIT = 31;
    localparam int MAG_MSB  = 30;

    localparam int FLAG_EQ = 0;
    localparam int FLAG_GT = 1;
    localparam int FLAG_LT = 2;
    localparam int N_FLAGS = 3;

    // Sign/magnitude order; +0 and -0 stay distinct, no NaN handling.
    function automatic logic [N_FLAGS-1:0] fp_compare(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [N_FLAGS-1:0] f;
        logic sa;
        logic sb;
        logic mag_gt;
        f  = '0;
        sa = a[SIGN_BIT];
        sb = b[SIGN_BIT];
        mag_gt = a[MAG_MSB:0] > b[MAG_MSB:0];
        if (sa != sb) begin
            f[FLAG_GT] = ~sa;
            f[FLAG_LT] = sa;
        end else if (a[MAG_MSB:0] == b[MAG_MSB:0]) begin
            f[FLAG_EQ] = 1'b1;
        end else begin
            f[FLAG_GT] = mag_gt ^ sa;
            f[FLAG_LT] = ~(mag_gt ^ sa);
        end
        return f;
    endfunction

endpackage

// File: rtl/fp_cmp_sched_if.sv
// Request/response bundle between FPU clients and the compare scheduler.
// master = clients and result consumer, slave = scheduler.
interface fp_cmp_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic                resp_aeb;
    logic                resp_agb;
    logic                resp_alb;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_id,
        input  resp_aeb,
        input  resp_agb,
        input  resp_alb
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_id,
        output resp_aeb,
        output resp_agb,
        output resp_alb
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid request at or after ptr.
// Produces a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             found
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        j     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ))
                sum = sum - (ID_W+1)'(N_REQ);
            j = sum[ID_W-1:0];
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/fp_cmp_sched.sv
// Shares one registered FP32 comparator among N_REQ requesters,
// round-robin arbitrated, with a buffered tagged EQ/GT/LT response.
module fp_cmp_sched
    import fp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    fp_cmp_sched_if.slave    bus,
    output logic             busy,
    output logic [CNT_W-1:0] cmp_count
);

    state_t state;
    state_t nxt;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    nxt_ptr;
    logic [N_REQ-1:0]   pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_found;
    logic               accept;
    logic               hs;

    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [ID_W-1:0]    id_q;
    logic               resp_valid_q;
    logic [ID_W-1:0]    resp_id_q;
    logic [N_FLAGS-1:0] flags_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign nxt_ptr = (pick_idx == ID_W'(N_REQ-1))
                   ? '0 : pick_idx + ID_W'(1);

    always_comb begin
        nxt    = state;
        accept = 1'b0;
        hs     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    accept = 1'b1;
                    nxt    = EVAL;
                end
            end
            EVAL: nxt = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    hs = 1'b1;
                    if (pick_found) begin
                        accept = 1'b1;
                        nxt    = EVAL;
                    end else begin
                        nxt = IDLE;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
        // Nothing may be granted while reset is held.
        if (rst) begin
            accept = 1'b0;
            hs     = 1'b0;
        end
    end

    assign bus.req_ready  = accept ? pick_grant : '0;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_aeb   = flags_q[FLAG_EQ];
    assign bus.resp_agb   = flags_q[FLAG_GT];
    assign bus.resp_alb   = flags_q[FLAG_LT];
    assign busy           = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            flags_q      <= '0;
            cmp_count    <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                a_q    <= bus.req_a[32*pick_idx +: 32];
                b_q    <= bus.req_b[32*pick_idx +: 32];
                id_q   <= pick_idx;
                rr_ptr <= nxt_ptr;
            end
            if (state == EVAL) begin
                flags_q      <= fp_compare(a_q, b_q);
                resp_id_q    <= id_q;
                resp_valid_q <= 1'b1;
            end
            // The old result retires on handshake even if a new one is queued.
            if (hs) begin
                resp_valid_q <= 1'b0;
                cmp_count    <= cmp_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp_cmp_sched.sv
// Directed bench for fp_cmp_sched: compare rule, round-robin order,
// back-pressure, reset mid-flight and counter wrap (CNT_W=4).
module tb_fp_cmp_sched;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 4;

    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic [CNT_W-1:0] cmp_count;

    int n_tests = 0;
    int n_fail  = 0;

    fp_cmp_sched_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    fp_cmp_sched #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .cmp_count (cmp_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] b);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_valid[i]      = 1'b1;
    endtask

    function automatic logic [2:0] flags();
        return {bus.resp_alb, bus.resp_agb, bus.resp_aeb};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Single isolated request, full round trip.
    task automatic do_one(input int i, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] exp,
                          input logic [CNT_W-1:0] cnt_after);
        set_req(i, a, b);
        #1;
        check($sformatf("one%0d_ready", i), 32'(bus.req_ready), 32'(1 << i));
        tick();
        bus.req_valid[i] = 1'b0;
        #1;
        check("one_eval_valid", 32'(bus.resp_valid), 32'd0);
        tick();
        check("one_valid", 32'(bus.resp_valid), 32'd1);
        check("one_id", 32'(bus.resp_id), 32'(i));
        check($sformatf("one%0d_flags", i), 32'(flags()), 32'(exp));
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        #1;
        check("one_drop", 32'(bus.resp_valid), 32'd0);
        check("one_cnt", 32'(cmp_count), 32'(cnt_after));
    endtask

    logic [31:0] rr_a [N_REQ];
    logic [31:0] rr_b [N_REQ];
    logic [2:0]  rr_e [N_REQ];

    initial begin
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;

        // req_ready must stay low during reset even with requests present
        bus.req_valid = '1;
        tick();
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        bus.req_valid = '0;
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_id", 32'(bus.resp_id), 32'd0);
        check("rst_flags", 32'(flags()), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(cmp_count), 32'd0);

        do_one(0, 32'h3F800000, 32'h40000000, LT, 4'd1);
        do_one(2, 32'hBF800000, 32'hC0000000, GT, 4'd2);
        do_one(2, 32'h00000000, 32'h80000000, GT, 4'd3);
        do_one(2, 32'h41200000, 32'h41200000, EQ, 4'd4);
        do_one(1, 32'h80000000, 32'h00000000, LT, 4'd5);
        do_one(3, 32'hBF800000, 32'h3F800000, LT, 4'd6);

        // Round robin with everyone requesting, consumer always ready
        do_reset();
        rr_a[0] = 32'h3F800000; rr_b[0] = 32'h40000000; rr_e[0] = LT;
        rr_a[1] = 32'h40000000; rr_b[1] = 32'h3F800000; rr_e[1] = GT;
        rr_a[2] = 32'h41200000; rr_b[2] = 32'h41200000; rr_e[2] = EQ;
        rr_a[3] = 32'hBF800000; rr_b[3] = 32'h3F800000; rr_e[3] = LT;
        for (int i = 0; i < N_REQ; i++) set_req(i, rr_a[i], rr_b[i]);
        bus.resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr%0d_grant", k), 32'(bus.req_ready),
                  32'(1 << (k % 4)));
            tick();
            check("rr_eval_valid", 32'(bus.resp_valid), 32'd0);
            tick();
            check("rr_valid", 32'(bus.resp_valid), 32'd1);
            check($sformatf("rr%0d_id", k), 32'(bus.resp_id), 32'(k % 4));
            check("rr_flags", 32'(flags()), 32'(rr_e[k % 4]));
            if (k == 5) bus.req_valid = '0;
            #1;
        end
        tick();
        check("rr_cnt", 32'(cmp_count), 32'd6);
        check("rr_idle", 32'(busy), 32'd0);

        // Back-pressure: rr_ptr now 2; requesters 2 and 3 pending
        bus.resp_ready = 1'b0;
        set_req(2, 32'hC0000000, 32'hBF800000);
        set_req(3, 32'h3F800000, 32'h3F800000);
        #1;
        check("bp_grant", 32'(bus.req_ready), 32'b0100);
        tick();
        bus.req_valid[2] = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(bus.resp_valid), 32'd1);
            check("bp_id", 32'(bus.resp_id), 32'd2);
            check("bp_flags", 32'(flags()), 32'(LT));
            check("bp_ready", 32'(bus.req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        bus.resp_ready = 1'b1;
        #1;
        check("bp_release", 32'(bus.req_ready), 32'b1000);
        tick();
        bus.req_valid[3] = 1'b0;
        #1;
        check("bp_cnt", 32'(cmp_count), 32'd7);
        check("bp_eval_valid", 32'(bus.resp_valid), 32'd0);
        check("bp_eval_busy", 32'(busy), 32'd1);
        tick();
        check("bp_id3", 32'(bus.resp_id), 32'd3);
        check("bp_flags3", 32'(flags()), 32'(EQ));
        tick();
        check("bp_cnt2", 32'(cmp_count), 32'd8);

        // Reset while in EVAL discards the in-flight request
        do_reset();
        bus.resp_ready = 1'b0;
        set_req(1, 32'h3F800000, 32'h40000000);
        tick();
        bus.req_valid[1] = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_valid", 32'(bus.resp_valid), 32'd0);
        check("mid_busy0", 32'(busy), 32'd0);
        check("mid_cnt", 32'(cmp_count), 32'd0);
        tick();
        check("mid_valid2", 32'(bus.resp_valid), 32'd0);
        set_req(3, 32'h3F800000, 32'h40000000);
        set_req(0, 32'h3F800000, 32'h40000000);
        #1;
        check("mid_ptr", 32'(bus.req_ready), 32'b0001);

        // Counter wrap: 17 responses on a 4-bit counter
        bus.resp_ready = 1'b1;
        tick();
        bus.req_valid[3] = 1'b0;
        #1;
        tick();
        for (int n = 1; n < 17; n++) begin
            tick();
            tick();
        end
        check("wrap_zero", 32'(cmp_count), 32'd0);
        check("wrap_valid", 32'(bus.resp_valid), 32'd1);
        bus.req_valid = '0;
        tick();
        check("wrap_one", 32'(cmp_count), 32'd1);
        check("wrap_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
